// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed, XOR-checksummed byte image, writes it word by
// word into instruction memory and keeps the core in reset until the image is verified.
module prog_loader #(
  parameter int          MAX_WORDS = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [15:0]       MAX_LEN    = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(32'd4);

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t            state_r, state_s;
  logic [15:0]       len_r, len_s, len_full_s;
  logic [15:0]       word_cnt_r, word_cnt_s;
  logic [1:0]        byte_cnt_r, byte_cnt_s;
  logic [7:0]        acc_r, acc_s;
  logic [23:0]       word_r, word_s;
  logic              imem_we_s, in_ready_s, core_reset_s, done_s, error_s;
  logic [ADDR_W-1:0] imem_addr_s;
  logic [31:0]       imem_wdata_s;
  logic              accept_s;

  assign accept_s = in_valid && in_ready;

  // Next-state and next-output computation; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_s      = state_r;
    len_s        = len_r;
    len_full_s   = {in_data, len_r[7:0]};
    word_cnt_s   = word_cnt_r;
    byte_cnt_s   = byte_cnt_r;
    acc_s        = acc_r;
    word_s       = word_r;
    imem_we_s    = 1'b0;
    imem_wdata_s = imem_wdata;
    imem_addr_s  = imem_we ? (imem_addr + WORD_BYTES) : imem_addr;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_s     = S_LEN0;
          acc_s       = 8'h00;
          word_cnt_s  = 16'h0000;
          byte_cnt_s  = 2'd0;
          imem_addr_s = BASE;
        end else begin
          state_s = state_r;
        end
      end
      S_LEN0: begin
        if (accept_s) begin
          len_s   = {8'h00, in_data};
          state_s = S_LEN1;
        end else begin
          state_s = S_LEN0;
        end
      end
      S_LEN1: begin
        if (accept_s) begin
          len_s = len_full_s;
          if (len_full_s > MAX_LEN) begin
            state_s = S_ERR;
          end else if (len_full_s == 16'h0000) begin
            state_s = S_CSUM;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = S_LEN1;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          acc_s      = csum_update(acc_r, in_data);
          byte_cnt_s = byte_cnt_r + 2'd1;
          case (byte_cnt_r)
            2'd0:    word_s[7:0]   = in_data;
            2'd1:    word_s[15:8]  = in_data;
            2'd2:    word_s[23:16] = in_data;
            default: begin
              // Fourth byte completes the word; the write strobe lands on the following cycle.
              imem_we_s    = 1'b1;
              imem_wdata_s = {in_data, word_r};
              word_cnt_s   = word_cnt_r + 16'd1;
              if ((word_cnt_r + 16'd1) == len_r) begin
                state_s = S_CSUM;
              end else begin
                state_s = S_DATA;
              end
            end
          endcase
        end else begin
          state_s = S_DATA;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          if (in_data == acc_r) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ERR;
          end
        end else begin
          state_s = S_CSUM;
        end
      end
      default: state_s = S_IDLE;
    endcase
    in_ready_s   = state_s inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    core_reset_s = (state_s != S_DONE);
    done_s       = (state_s == S_DONE);
    error_s      = (state_s == S_ERR);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_r      <= 16'h0000;
      word_cnt_r <= 16'h0000;
      byte_cnt_r <= 2'd0;
      acc_r      <= 8'h00;
      word_r     <= 24'h000000;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 32'h0000_0000;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      len_r      <= len_s;
      word_cnt_r <= word_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      acc_r      <= acc_s;
      word_r     <= word_s;
      in_ready   <= in_ready_s;
      imem_we    <= imem_we_s;
      imem_addr  <= imem_addr_s;
      imem_wdata <= imem_wdata_s;
      core_reset <= core_reset_s;
      done       <= done_s;
      error      <= error_s;
    end
  end

endmodule
